// File: rtl/rot_shift_sequencer.sv
// rot_shift_sequencer: sequenced bit-rotate engine.
// A request (word + amount) is accepted over a valid/ready handshake and
// rotated one bit per clock in a rotation register. The result is then
// presented on a valid/ready output handshake. This avoids a barrel shifter.
//
// Optional feature macro: ROT_DIR_EN
//   defined   : in_dir is latched at accept (0 = right, 1 = left)
//   undefined : in_dir is ignored and every rotation is a right rotation
module rot_shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_rot;
    logic [AMT_W-1:0] r_cnt;
    logic [AMT_W-1:0] w_amt;
    logic             w_accept;
    logic             w_rotate;
    logic [WIDTH-1:0] w_rot_step;

    // Amounts >= WIDTH can only occur for non-power-of-two widths; fold them.
    assign w_amt    = AMT_W'(32'(in_amt) % WIDTH);

    // Flush beats both the accept and the output handshake.
    assign w_accept = (r_state == S_IDLE) && in_valid && !flush;
    assign w_rotate = (r_state == S_SHIFT) && !flush;

`ifdef ROT_DIR_EN
    logic r_dir;

    // Direction is captured with the request and held for the whole operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir <= 1'b0;
        end else if (w_accept) begin
            r_dir <= in_dir;
        end
    end

    // Single-bit rotation in the latched direction.
    always_comb begin
        w_rot_step = {r_rot[0], r_rot[WIDTH-1:1]};
        if (r_dir) begin
            w_rot_step = {r_rot[WIDTH-2:0], r_rot[WIDTH-1]};
        end
    end
`else
    // Port kept for interface stability; nothing consumes it in this build.
    logic w_unused_dir;
    assign w_unused_dir = in_dir;

    // Single-bit right rotation only.
    always_comb begin
        w_rot_step = {r_rot[0], r_rot[WIDTH-1:1]};
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a zero amount skips SHIFT so count never underflows.
    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        w_next = (w_amt == '0) ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == AMT_W'(1)) begin
                        w_next = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        w_next = S_IDLE;
                    end
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Moore outputs; out_data always mirrors the register, qualified by out_valid.
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
        out_data  = r_rot;
    end

    // Datapath: load on accept, rotate and count down while shifting.
    // A flush leaves the register and count untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rot <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_rot <= in_data;
            r_cnt <= w_amt;
        end else if (w_rotate) begin
            r_rot <= w_rot_step;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - AMT_W'(1);
            end
        end
    end

endmodule
